// File: rtl/fx_writeback_stage.sv
// rtl/fx_writeback_stage.sv - FX writeback stage: captures results, computes CR0, queues in order for GPR writeback
module fx_writeback_stage #(
    parameter int         regWidth      = 5,
    parameter int         fifoDepthLog2 = 2,
    parameter logic [0:2] FXUnitCode    = 3'd0
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [0:2]          functionalUnitCode_i,
    input  logic                reg1WritebackEnable_i,
    input  logic [regWidth-1:0] reg1WritebackAddress_i,
    input  logic [0:63]         reg1WritebackVal_i,
    input  logic                reg2WritebackEnable_i,
    input  logic [0:63]         reg2WritebackVal_i,
    input  logic                carryValid_i,
    input  logic                is64Bit_i,
    input  logic                xerSO_i,
    input  logic                gprWriteAck_i,
    output logic                stall_o,
    output logic                gprWriteEnable_o,
    output logic [regWidth-1:0] gprWriteAddress_o,
    output logic [0:63]         gprWriteVal_o,
    output logic                crWriteEnable_o,
    output logic [0:3]          crField_o,
    output logic                caWriteEnable_o,
    output logic                ca_o,
    output logic                overflow_o
);

    localparam int DEPTH = 1 << fifoDepthLog2;
    localparam int PW    = fifoDepthLog2;
    localparam int CW    = fifoDepthLog2 + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [regWidth-1:0] addr_mem_q [DEPTH];
    logic [0:63]         val_mem_q  [DEPTH];
    logic [0:3]          cr_mem_q   [DEPTH];
    logic                rec_mem_q  [DEPTH];
    logic                cv_mem_q   [DEPTH];
    logic                ca_mem_q   [DEPTH];

    logic       fu_match;
    logic       push;
    logic       pop;
    logic       head_valid;
    logic       cr_lt;
    logic       cr_eq;
    logic [0:3] cr_d;
    logic       unused_reg2;

    // Only bit 0 of the second result port carries information (carry out).
    assign unused_reg2 = ^reg2WritebackVal_i[1:63];

    assign fu_match   = (functionalUnitCode_i == FXUnitCode);
    assign stall_o    = (count_q == CW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign push       = reg1WritebackEnable_i && fu_match && !stall_o;
    assign pop        = head_valid && gprWriteAck_i;

    // CR0 is resolved at capture so the mode/SO inputs need not be held until retire.
    always_comb begin
        cr_lt = is64Bit_i ? reg1WritebackVal_i[0] : reg1WritebackVal_i[32];
        cr_eq = is64Bit_i ? (reg1WritebackVal_i == 64'd0)
                          : (reg1WritebackVal_i[32:63] == 32'd0);
        cr_d  = {cr_lt, !cr_lt && !cr_eq, cr_eq, xerSO_i};
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (reg1WritebackEnable_i && fu_match && stall_o) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clock_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= reg1WritebackAddress_i;
            val_mem_q[wr_ptr_q]  <= reg1WritebackVal_i;
            cr_mem_q[wr_ptr_q]   <= cr_d;
            rec_mem_q[wr_ptr_q]  <= reg2WritebackEnable_i;
            cv_mem_q[wr_ptr_q]   <= carryValid_i;
            ca_mem_q[wr_ptr_q]   <= reg2WritebackVal_i[0];
        end
    end

    assign gprWriteEnable_o  = head_valid;
    assign gprWriteAddress_o = head_valid ? addr_mem_q[rd_ptr_q] : '0;
    assign gprWriteVal_o     = head_valid ? val_mem_q[rd_ptr_q]  : '0;
    assign crField_o         = head_valid ? cr_mem_q[rd_ptr_q]   : '0;
    assign ca_o              = head_valid ? ca_mem_q[rd_ptr_q]   : 1'b0;
    assign crWriteEnable_o   = pop && rec_mem_q[rd_ptr_q];
    assign caWriteEnable_o   = pop && cv_mem_q[rd_ptr_q];
    assign overflow_o        = overflow_q;

endmodule

// File: tb/tb_fx_writeback_stage.sv
// tb/tb_fx_writeback_stage.sv - scoreboard bench for fx_writeback_stage with directed and random stimulus
module tb_fx_writeback_stage;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] val;
        logic [3:0]  cr;
        logic        rec;
        logic        cv;
        logic        ca;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:2]  fu_code = '0;
    logic        r1_en = 1'b0;
    logic [4:0]  r1_addr = '0;
    logic [0:63] r1_val = '0;
    logic        r2_en = 1'b0;
    logic [0:63] r2_val = '0;
    logic        carry_valid = 1'b0;
    logic        is64 = 1'b0;
    logic        xer_so = 1'b0;
    logic        ack = 1'b0;

    logic        stall;
    logic        gpr_we;
    logic [4:0]  gpr_addr;
    logic [0:63] gpr_val;
    logic        cr_we;
    logic [0:3]  cr_field;
    logic        ca_we;
    logic        ca;
    logic        overflow;

    ent_t sb[$];
    bit   exp_ovf = 1'b0;
    bit   in_reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    fx_writeback_stage #(.regWidth(5), .fifoDepthLog2(2), .FXUnitCode(3'd0)) dut (
        .clock_i               (clk),
        .reset_i               (rst_n),
        .functionalUnitCode_i  (fu_code),
        .reg1WritebackEnable_i (r1_en),
        .reg1WritebackAddress_i(r1_addr),
        .reg1WritebackVal_i    (r1_val),
        .reg2WritebackEnable_i (r2_en),
        .reg2WritebackVal_i    (r2_val),
        .carryValid_i          (carry_valid),
        .is64Bit_i             (is64),
        .xerSO_i               (xer_so),
        .gprWriteAck_i         (ack),
        .stall_o               (stall),
        .gprWriteEnable_o      (gpr_we),
        .gprWriteAddress_o     (gpr_addr),
        .gprWriteVal_o         (gpr_val),
        .crWriteEnable_o       (cr_we),
        .crField_o             (cr_field),
        .caWriteEnable_o       (ca_we),
        .ca_o                  (ca),
        .overflow_o            (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_cr(input logic [63:0] v, input bit m64, input bit so);
        longint s;
        bit lt, eq;
        s  = m64 ? longint'(v) : longint'(int'(v[31:0]));
        lt = (s < 0);
        eq = (s == 0);
        return {lt, !lt && !eq, eq, so};
    endfunction

    // One clock of stimulus, starting and ending just after a rising edge.
    task automatic cycle(input bit vld, input logic [2:0] code, input logic [4:0] addr,
                         input logic [63:0] val, input bit rec, input bit car, input bit cv,
                         input bit m64, input bit so, input bit ak);
        bit   accept;
        bit   dropped;
        ent_t e;
        accept  = vld && (code == 3'd0) && (sb.size() < DEPTH);
        dropped = vld && (code == 3'd0) && (sb.size() == DEPTH);
        e.addr = addr;
        e.val  = val;
        e.cr   = model_cr(val, m64, so);
        e.rec  = rec;
        e.cv   = cv;
        e.ca   = car;
        r1_en = vld; fu_code = code; r1_addr = addr; r1_val = val;
        r2_en = rec; r2_val = {$urandom, $urandom}; r2_val[0] = car;
        carry_valid = cv; is64 = m64; xer_so = so; ack = ak;
        @(posedge clk);
        #1;
        if (accept) sb.push_back(e);
        if (dropped) exp_ovf = 1'b1;
    endtask

    task automatic push1(input logic [4:0] addr, input logic [63:0] val, input bit ak);
        cycle(1'b1, 3'd0, addr, val, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ak);
    endtask

    task automatic idle(input bit ak);
        cycle(1'b0, 3'd0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ak);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    gpr_we, 0);
        chk({tag, "_addr"},  gpr_addr, 0);
        chk({tag, "_val"},   gpr_val, 0);
        chk({tag, "_cr"},    cr_field, 0);
        chk({tag, "_crwe"},  cr_we, 0);
        chk({tag, "_cawe"},  ca_we, 0);
        chk({tag, "_ca"},    ca, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_ovf"},   overflow, 0);
    endtask

    // Monitor: mid-cycle, compares the head against the scoreboard and retires it on ack.
    initial begin
        ent_t h;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                chk("mon_we",    gpr_we, sb.size() != 0);
                chk("mon_stall", stall, sb.size() == DEPTH);
                chk("mon_ovf",   overflow, exp_ovf);
                if (sb.size() != 0) begin
                    h = sb[0];
                    chk("mon_addr", gpr_addr, h.addr);
                    chk("mon_val",  gpr_val, h.val);
                    chk("mon_cr",   cr_field, h.cr);
                    chk("mon_ca",   ca, h.ca);
                    chk("mon_crwe", cr_we, ack && h.rec);
                    chk("mon_cawe", ca_we, ack && h.cv);
                    if (ack) void'(sb.pop_front());
                end else begin
                    chk("mon_e_addr", gpr_addr, 0);
                    chk("mon_e_val",  gpr_val, 0);
                    chk("mon_e_cr",   cr_field, 0);
                    chk("mon_e_ca",   ca, 0);
                    chk("mon_e_crwe", cr_we, 0);
                    chk("mon_e_cawe", ca_we, 0);
                end
            end
        end
    end

    initial begin
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_reset = 1'b0;

        // Single entry held until acknowledged
        push1(5'd3, 64'h10, 1'b0);
        chk("t1_we", gpr_we, 1);
        chk("t1_addr", gpr_addr, 3);
        chk("t1_val", gpr_val, 64'h10);
        repeat (3) idle(1'b0);
        idle(1'b1);

        // Fill, overflow drop, drain in order
        for (int i = 0; i < 4; i++) push1(5'(i + 8), 64'h100 + 64'(i), 1'b0);
        chk("t2_stall", stall, 1);
        push1(5'd31, 64'hDEAD, 1'b0);
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("t2_empty", gpr_we, 0);

        // Push and pop in the same cycle at count 3, wrapping pointers
        for (int i = 0; i < 3; i++) push1(5'(i), 64'h200 + 64'(i), 1'b0);
        for (int i = 0; i < 10; i++) push1(5'(i + 3), 64'h300 + 64'(i), 1'b1);
        chk("t3_stall", stall, 0);
        repeat (3) idle(1'b1);

        // Record form CR0 in both modes
        cycle(1'b1, 3'd0, 5'd4, 64'hFFFFFFFF_00000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_cr64", cr_field, 4'b1001);
        chk("t4_crwe_hold", cr_we, 0);
        cycle(1'b1, 3'd0, 5'd5, 64'hFFFFFFFF_00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_cr32", cr_field, 4'b0011);
        idle(1'b1);

        // Carry-only entry
        cycle(1'b1, 3'd0, 5'd6, 64'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Non-matching unit code is ignored
        cycle(1'b1, 3'd5, 5'd7, 64'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fu_ignored", gpr_we, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                  5'($urandom),
                  ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom},
                  1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 5);
        end

        // Reset mid-cycle with entries queued
        while (sb.size() != 0) idle(1'b1);
        push1(5'd1, 64'hA, 1'b0);
        push1(5'd2, 64'hB, 1'b0);
        idle(1'b0);
        #2;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        sb.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        chk("t6_after_we", gpr_we, 0);
        repeat (3) idle(1'b1);
        push1(5'd9, 64'h99, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
